// File: rtl/bcd_cvt_sched_pkg.sv
// Shared types and elaboration helpers for the BCD converter scheduler.
package bcd_cvt_sched_pkg;

  typedef enum logic [2:0] {
    S_FLUSH   = 3'd0,
    S_IDLE    = 3'd1,
    S_REQ     = 3'd2,
    S_COLLECT = 3'd3,
    S_DONE    = 3'd4
  } type_enum_sched_fsm;

  // Worst-case converter latency from start pulse to the last digit strobe.
  function automatic int unsigned min_timeout(input int unsigned bin_w,
                                              input int unsigned dec_d);
    return bin_w * (dec_d + 1) + dec_d + 2;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant.
module rr_arbiter
  import bcd_cvt_sched_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]                     req,
  input  logic                             en,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] last,
  output logic [N-1:0]                     gnt,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      w_idx = IW'((32'(last) + off) % N);
      if (en && !w_found && req[w_idx]) begin
        w_found      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = w_idx;
      end
    end
  end

endmodule

// File: rtl/bcd_cvt_sched.sv
// Shares one serial binary-to-BCD converter between N_REQ requesters and
// commits each result atomically into a per-requester BCD bank.
module bcd_cvt_sched
  import bcd_cvt_sched_pkg::*;
#(
  parameter int unsigned N_REQ         = 2,
  parameter int unsigned BIN_VAL_WIDTH = 14,
  parameter int unsigned DEC_DIGITS    = 4,
  parameter int unsigned TIMEOUT       = 128
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [N_REQ-1:0]                          req_valid_i,
  output logic [N_REQ-1:0]                          req_ready_o,
  input  logic [N_REQ*BIN_VAL_WIDTH-1:0]            req_bin_i,
  output logic [BIN_VAL_WIDTH-1:0]                  cvt_bin_o,
  output logic                                      cvt_req_o,
  input  logic [3:0]                                cvt_digit_i,
  input  logic [DEC_DIGITS-1:0]                     cvt_resp_i,
  output logic [N_REQ*DEC_DIGITS*4-1:0]             digits_o,
  output logic                                      done_o,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] done_id_o,
  output logic                                      err_o,
  output logic                                      busy_o
);

  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned BW  = DEC_DIGITS * 4;
  localparam int unsigned TW  = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  if (TIMEOUT < min_timeout(BIN_VAL_WIDTH, DEC_DIGITS)) begin : g_timeout_chk
    $error("bcd_cvt_sched: TIMEOUT shorter than converter worst-case latency");
  end

  type_enum_sched_fsm r_state, w_next;

  logic [TW-1:0]            r_timer;
  logic [BW-1:0]            r_shadow;
  logic [IDW-1:0]           r_last;
  logic [IDW-1:0]           r_gid;
  logic [BIN_VAL_WIDTH-1:0] r_bin;
  logic [N_REQ*BW-1:0]      r_banks;
  logic                     r_bad;
  logic                     r_tmo;

  logic [N_REQ-1:0]         w_gnt;
  logic [IDW-1:0]           w_gnt_idx;
  logic [BIN_VAL_WIDTH-1:0] w_sel_bin;
  logic                     w_accept;
  logic                     w_last_strobe;
  logic                     w_tmr_end;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid_i),
    .en      (r_state == S_IDLE),
    .last    (r_last),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_accept      = |w_gnt;
  assign w_last_strobe = cvt_resp_i[DEC_DIGITS-1];
  assign w_tmr_end     = (r_timer == TMAX);

  always_comb begin
    w_sel_bin = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) w_sel_bin = req_bin_i[i*BIN_VAL_WIDTH +: BIN_VAL_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FLUSH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    cvt_req_o = 1'b0;
    done_o    = 1'b0;
    done_id_o = '0;
    err_o     = 1'b0;
    busy_o    = 1'b1;
    case (r_state)
      S_FLUSH:   if (w_last_strobe || w_tmr_end) w_next = S_IDLE;
      S_IDLE: begin
        busy_o = 1'b0;
        if (w_accept) w_next = S_REQ;
      end
      S_REQ: begin
        cvt_req_o = 1'b1;
        w_next    = S_COLLECT;
      end
      S_COLLECT: if (w_last_strobe || w_tmr_end) w_next = S_DONE;
      S_DONE: begin
        done_o    = 1'b1;
        done_id_o = r_gid;
        err_o     = r_bad | r_tmo;
        w_next    = r_tmo ? S_FLUSH : S_IDLE;
      end
      default:   w_next = S_FLUSH;
    endcase
  end

  // Timer runs from the start pulse so a timeout lands exactly TIMEOUT cycles later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer  <= '0;
      r_shadow <= '0;
      r_last   <= IDW'(N_REQ - 1);
      r_gid    <= '0;
      r_bin    <= '0;
      r_banks  <= '0;
      r_bad    <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      case (r_state)
        S_FLUSH: r_timer <= r_timer + 1'b1;
        S_IDLE: begin
          if (w_accept) begin
            r_bin    <= w_sel_bin;
            r_gid    <= w_gnt_idx;
            r_last   <= w_gnt_idx;
            r_shadow <= '0;
            r_timer  <= '0;
            r_bad    <= 1'b0;
            r_tmo    <= 1'b0;
          end
        end
        S_REQ: r_timer <= r_timer + 1'b1;
        S_COLLECT: begin
          r_timer <= r_timer + 1'b1;
          for (int unsigned k = 0; k < DEC_DIGITS; k++) begin
            if (cvt_resp_i[k]) begin
              r_shadow[k*4 +: 4] <= cvt_digit_i;
              if (cvt_digit_i > 4'd9) r_bad <= 1'b1;
            end
          end
          if (!w_last_strobe && w_tmr_end) r_tmo <= 1'b1;
        end
        S_DONE: begin
          r_timer <= '0;
          if (!(r_bad || r_tmo)) begin
            for (int unsigned b = 0; b < N_REQ; b++) begin
              if (r_gid == IDW'(b)) r_banks[b*BW +: BW] <= r_shadow;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cvt_bin_o = r_bin;
  assign digits_o  = r_banks;
  assign req_ready_o = w_gnt;

endmodule

// File: tb/tb_bcd_cvt_sched.sv
// Directed bench for bcd_cvt_sched with a behavioural serial converter model.
module tb_bcd_cvt_sched;

  localparam int unsigned N       = 2;
  localparam int unsigned W       = 14;
  localparam int unsigned D       = 4;
  localparam int unsigned TO      = 128;
  localparam int unsigned CVT_LAT = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_bin;
  logic [W-1:0]   cvt_bin;
  logic           cvt_req;
  logic [3:0]     cvt_digit;
  logic [D-1:0]   cvt_resp;
  logic [N*D*4-1:0] digits;
  logic           done;
  logic [0:0]     done_id;
  logic           err;
  logic           busy;

  int unsigned n_vec = 0, n_err = 0;
  int unsigned cyc = 0, req_cyc = 0, strobe_cyc = 0, n_done = 0, viol = 0;
  int unsigned cvt_mode = 0;  // 0 normal, 1 silent, 2 bad digit 1

  typedef struct {
    int unsigned mode;
    logic [1:0]  valid;
    logic [W-1:0] bin0;
    logic [W-1:0] bin1;
    int unsigned exp_id;
    logic        exp_err;
    logic        exp_tmo;
    logic [15:0] exp_b0;
    logic [15:0] exp_b1;
  } vec_t;

  vec_t tbl[7];

  bcd_cvt_sched #(
    .N_REQ(N), .BIN_VAL_WIDTH(W), .DEC_DIGITS(D), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_bin_i(req_bin),
    .cvt_bin_o(cvt_bin), .cvt_req_o(cvt_req),
    .cvt_digit_i(cvt_digit), .cvt_resp_i(cvt_resp),
    .digits_o(digits), .done_o(done), .done_id_o(done_id),
    .err_o(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // cyc numbers the edge that ends the sampled cycle
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cvt_req) req_cyc = cyc;
    if (cvt_resp[D-1]) strobe_cyc = cyc;
    if (done) n_done = n_done + 1;
    if ($countones(req_ready) > 1) viol = viol + 1;
  end

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  logic [W-1:0] m_val;
  always begin
    @(posedge clk);
    if (cvt_req && cvt_mode != 1) begin
      m_val = cvt_bin;
      repeat (CVT_LAT) @(negedge clk);
      for (int k = 0; k < int'(D); k++) begin
        cvt_resp    = '0;
        cvt_resp[k] = 1'b1;
        cvt_digit   = (cvt_mode == 2 && k == 1) ? 4'hA
                                                : 4'((int'(m_val) / pow10(k)) % 10);
        @(negedge clk);
      end
      cvt_resp  = '0;
      cvt_digit = '0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    bit ok;
    logic [W-1:0] bexp;
    int unsigned cnt;
    v    = tbl[idx];
    bexp = (v.exp_id == 0) ? v.bin0 : v.bin1;
    @(negedge clk);
    cvt_mode  = v.mode;
    req_bin   = {v.bin1, v.bin0};
    req_valid = v.valid;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      if ((req_ready & req_valid) != '0) begin ok = 1; break; end
    end
    chk($sformatf("v%0d_accept", idx), 32'(ok), 1);
    if (!ok) begin req_valid = '0; return; end
    chk($sformatf("v%0d_grant", idx), 32'(req_ready), 32'(1) << v.exp_id);
    @(negedge clk);
    req_valid = '0;
    chk($sformatf("v%0d_cvt_req", idx), 32'(cvt_req), 1);
    chk($sformatf("v%0d_cvt_bin", idx), 32'(cvt_bin), 32'(bexp));
    ok = 0;
    for (int n = 0; n < int'(TO) + 40; n++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    chk($sformatf("v%0d_done_seen", idx), 32'(ok), 1);
    if (!ok) return;
    chk($sformatf("v%0d_done_id", idx), 32'(done_id), v.exp_id);
    chk($sformatf("v%0d_err", idx), 32'(err), 32'(v.exp_err));
    chk($sformatf("v%0d_cvt_bin_hold", idx), 32'(cvt_bin), 32'(bexp));
    if (v.exp_tmo) chk($sformatf("v%0d_tmo_latency", idx), cyc + 1 - req_cyc, TO);
    else           chk($sformatf("v%0d_done_latency", idx), cyc + 1 - strobe_cyc, 1);
    if (v.exp_tmo) begin
      // DONE cycle plus a full TIMEOUT-long flush
      cnt = 0;
      for (int n = 0; n < int'(TO) + 40; n++) begin
        @(posedge clk); #1;
        cnt++;
        if (!busy) break;
      end
      chk($sformatf("v%0d_flush_len", idx), cnt, TO + 1);
    end else begin
      @(negedge clk);
    end
    chk($sformatf("v%0d_bank0", idx), 32'(digits[15:0]), 32'(v.exp_b0));
    chk($sformatf("v%0d_bank1", idx), 32'(digits[31:16]), 32'(v.exp_b1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int unsigned cnt, dbefore;
    int unsigned exp_seq[4];

    tbl[0] = '{0, 2'b01, 14'd1234, 14'd0,    0, 1'b0, 1'b0, 16'h1234, 16'h0000};
    tbl[1] = '{0, 2'b10, 14'd0,    14'd567,  1, 1'b0, 1'b0, 16'h1234, 16'h0567};
    tbl[2] = '{2, 2'b01, 14'd4321, 14'd0,    0, 1'b1, 1'b0, 16'h1234, 16'h0567};
    tbl[3] = '{1, 2'b10, 14'd0,    14'd42,   1, 1'b1, 1'b1, 16'h1234, 16'h0567};
    tbl[4] = '{0, 2'b11, 14'd7,    14'd8,    0, 1'b0, 1'b0, 16'h0007, 16'h0567};
    tbl[5] = '{0, 2'b11, 14'd2468, 14'd1357, 0, 1'b0, 1'b0, 16'h2468, 16'h0000};
    tbl[6] = '{0, 2'b10, 14'd0,    14'd1357, 1, 1'b0, 1'b0, 16'h2468, 16'h1357};
    exp_seq = '{0, 1, 0, 1};

    req_valid = '0;
    req_bin   = '0;
    cvt_resp  = '0;
    cvt_digit = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready",   32'(req_ready), 0);
    chk("rst_cvt_req", 32'(cvt_req), 0);
    chk("rst_cvt_bin", 32'(cvt_bin), 0);
    chk("rst_done",    32'(done), 0);
    chk("rst_done_id", 32'(done_id), 0);
    chk("rst_err",     32'(err), 0);
    chk("rst_busy",    32'(busy), 1);
    chk("rst_digits",  32'(digits), 0);

    rst = 1'b0;
    dbefore = n_done;
    cnt = 0;
    for (int n = 0; n < int'(TO) + 40; n++) begin
      @(posedge clk); #1;
      cnt++;
      if (!busy) break;
    end
    chk("flush_len", cnt, TO);
    chk("flush_no_done", n_done - dbefore, 0);

    // both requesters held valid: grants must alternate starting at 0
    @(negedge clk);
    cvt_mode  = 0;
    req_bin   = {14'd0, 14'd9999};
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      ok = 0;
      for (int n = 0; n < int'(TO) + 40; n++) begin
        @(negedge clk);
        if (done) begin ok = 1; break; end
      end
      chk($sformatf("rr%0d_done_seen", i), 32'(ok), 1);
      if (!ok) break;
      chk($sformatf("rr%0d_done_id", i), 32'(done_id), exp_seq[i]);
      chk($sformatf("rr%0d_err", i), 32'(err), 0);
      if (i == 3) req_valid = '0;
    end
    req_valid = '0;
    @(negedge clk);
    chk("rr_bank0", 32'(digits[15:0]), 32'h9999);
    chk("rr_bank1", 32'(digits[31:16]), 32'h0000);

    for (int i = 0; i < 5; i++) run_vec(i);

    // reset while the converter is mid-way through its strobes
    @(negedge clk);
    cvt_mode  = 0;
    req_bin   = {14'd0, 14'd5555};
    req_valid = 2'b01;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      if (req_ready[0]) begin ok = 1; break; end
    end
    chk("mid_rst_accept", 32'(ok), 1);
    @(negedge clk);
    req_valid = '0;
    dbefore = n_done;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      if (cvt_resp[0]) begin ok = 1; break; end
    end
    chk("mid_rst_strobe0", 32'(ok), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready",   32'(req_ready), 0);
    chk("mid_rst_cvt_req", 32'(cvt_req), 0);
    chk("mid_rst_cvt_bin", 32'(cvt_bin), 0);
    chk("mid_rst_done",    32'(done), 0);
    chk("mid_rst_err",     32'(err), 0);
    chk("mid_rst_busy",    32'(busy), 1);
    chk("mid_rst_digits",  32'(digits), 0);
    rst = 1'b0;
    // strobes 2 and 3 still arrive; strobe 3 ends the flush on the second edge
    cnt = 0;
    for (int n = 0; n < int'(TO) + 40; n++) begin
      @(posedge clk); #1;
      cnt++;
      if (!busy) break;
    end
    chk("mid_rst_flush_len", cnt, 2);
    chk("mid_rst_no_done", n_done - dbefore, 0);

    for (int i = 5; i < 7; i++) run_vec(i);

    chk("ready_onehot", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
